sdrc_req_arbiter: RTL and testbench

//  Two-port round-robin arbiter in front of the SDRAM controller application request interface.

---
 rtl/sdrc_req_arbiter.sv | 124 ++++++++++++
 tb/tb_sdrc_req_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_req_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller request port.
// The grant is held from request through the last data beat of the burst.
module sdrc_req_arbiter #(
  parameter int APP_AW = 30,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            app_req,
  input  logic [2*APP_AW-1:0]   app_req_addr,
  input  logic [2*APP_RW-1:0]   app_req_len,
  input  logic [1:0]            app_req_wr_n,
  input  logic [1:0]            app_req_dma_last,
  output logic [1:0]            app_req_ack,
  input  logic [2*APP_DW-1:0]   app_wr_data,
  input  logic [2*APP_BW-1:0]   app_wr_en_n,
  output logic [1:0]            app_wr_next,
  output logic [APP_DW-1:0]     app_rd_data,
  output logic [1:0]            app_rd_valid,
  output logic                  mc_req,
  output logic [APP_AW-1:0]     mc_req_addr,
  output logic [APP_RW-1:0]     mc_req_len,
  output logic                  mc_req_wr_n,
  output logic                  mc_req_dma_last,
  input  logic                  mc_req_ack,
  output logic [APP_DW-1:0]     mc_wr_data,
  output logic [APP_BW-1:0]     mc_wr_en_n,
  input  logic                  mc_wr_next,
  input  logic [APP_DW-1:0]     mc_rd_data,
  input  logic                  mc_rd_valid,
  output logic                  arb_grant,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t              state, state_nxt;
  logic                grant_nxt;
  logic                last_served, last_nxt;
  logic [APP_RW-1:0]   beat_cnt, cnt_nxt;
  logic                dir, dir_nxt;
  logic                strobe;

  // Request and write-data muxes follow the registered grant in every state.
  assign mc_req_addr     = arb_grant ? app_req_addr[2*APP_AW-1:APP_AW] : app_req_addr[APP_AW-1:0];
  assign mc_req_len      = arb_grant ? app_req_len[2*APP_RW-1:APP_RW]  : app_req_len[APP_RW-1:0];
  assign mc_req_wr_n     = app_req_wr_n[arb_grant];
  assign mc_req_dma_last = app_req_dma_last[arb_grant];
  assign mc_wr_data      = arb_grant ? app_wr_data[2*APP_DW-1:APP_DW]  : app_wr_data[APP_DW-1:0];
  assign mc_wr_en_n      = arb_grant ? app_wr_en_n[2*APP_BW-1:APP_BW]  : app_wr_en_n[APP_BW-1:0];
  assign app_rd_data     = mc_rd_data;
  assign arb_busy        = (state != IDLE);

  // dir=1 means a read burst, so only read strobes count beats and vice versa.
  assign strobe = dir ? mc_rd_valid : mc_wr_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      arb_grant   <= 1'b0;
      last_served <= 1'b1;
      beat_cnt    <= '0;
      dir         <= 1'b0;
    end else begin
      state       <= state_nxt;
      arb_grant   <= grant_nxt;
      last_served <= last_nxt;
      beat_cnt    <= cnt_nxt;
      dir         <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = arb_grant;
    last_nxt     = last_served;
    cnt_nxt      = beat_cnt;
    dir_nxt      = dir;
    mc_req       = 1'b0;
    app_req_ack  = 2'b00;
    app_wr_next  = 2'b00;
    app_rd_valid = 2'b00;
    case (state)
      IDLE: begin
        if (|app_req) begin
          grant_nxt = (&app_req) ? ~last_served : app_req[1];
          state_nxt = REQ;
        end
      end
      REQ: begin
        mc_req = app_req[arb_grant];
        if (!app_req[arb_grant]) begin
          state_nxt = IDLE;
        end else if (mc_req_ack) begin
          app_req_ack[arb_grant] = 1'b1;
          // A zero-length request has no data phase and completes on accept.
          if (mc_req_len == '0) begin
            state_nxt = IDLE;
            last_nxt  = arb_grant;
          end else begin
            cnt_nxt   = mc_req_len;
            dir_nxt   = mc_req_wr_n;
            state_nxt = XFER;
          end
        end
      end
      XFER: begin
        app_wr_next[arb_grant]  = ~dir & mc_wr_next;
        app_rd_valid[arb_grant] = dir & mc_rd_valid;
        if (strobe) begin
          cnt_nxt = beat_cnt - APP_RW'(1);
          if (beat_cnt == APP_RW'(1)) begin
            state_nxt = IDLE;
            last_nxt  = arb_grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// Self-checking bench for sdrc_req_arbiter: directed scenarios plus a
// randomized run against a transaction-level ownership model.
module tb_sdrc_req_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int RW = 9;

  logic            clk;
  logic            reset_n;
  logic [1:0]      app_req;
  logic [2*AW-1:0] app_req_addr;
  logic [2*RW-1:0] app_req_len;
  logic [1:0]      app_req_wr_n;
  logic [1:0]      app_req_dma_last;
  logic [1:0]      app_req_ack;
  logic [2*DW-1:0] app_wr_data;
  logic [2*BW-1:0] app_wr_en_n;
  logic [1:0]      app_wr_next;
  logic [DW-1:0]   app_rd_data;
  logic [1:0]      app_rd_valid;
  logic            mc_req;
  logic [AW-1:0]   mc_req_addr;
  logic [RW-1:0]   mc_req_len;
  logic            mc_req_wr_n;
  logic            mc_req_dma_last;
  logic            mc_req_ack;
  logic [DW-1:0]   mc_wr_data;
  logic [BW-1:0]   mc_wr_en_n;
  logic            mc_wr_next;
  logic [DW-1:0]   mc_rd_data;
  logic            mc_rd_valid;
  logic            arb_grant;
  logic            arb_busy;

  int n_cmp = 0;
  int n_err = 0;

  sdrc_req_arbiter #(.APP_AW(AW), .APP_DW(DW), .APP_BW(BW), .APP_RW(RW)) dut (
    .clk(clk), .reset_n(reset_n),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_dma_last(app_req_dma_last),
    .app_req_ack(app_req_ack), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next(app_wr_next), .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid),
    .mc_req(mc_req), .mc_req_addr(mc_req_addr), .mc_req_len(mc_req_len),
    .mc_req_wr_n(mc_req_wr_n), .mc_req_dma_last(mc_req_dma_last), .mc_req_ack(mc_req_ack),
    .mc_wr_data(mc_wr_data), .mc_wr_en_n(mc_wr_en_n), .mc_wr_next(mc_wr_next),
    .mc_rd_data(mc_rd_data), .mc_rd_valid(mc_rd_valid),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    app_req = '0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = '0;
    app_req_dma_last = '0; app_wr_data = '0; app_wr_en_n = '0;
    mc_req_ack = 1'b0; mc_wr_next = 1'b0; mc_rd_data = '0; mc_rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    app_req = 2'b11; mc_req_ack = 1'b1; mc_wr_next = 1'b1; mc_rd_valid = 1'b1;
    cyc();
    cyc();
    settle();
    n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mc_req: got %b want 0", mc_req); end
    n_cmp++; if (app_req_ack !== 2'b00) begin n_err++; $display("[TB] FAIL rst_ack: got %b want 00", app_req_ack); end
    n_cmp++; if (app_wr_next !== 2'b00) begin n_err++; $display("[TB] FAIL rst_wr_next: got %b want 00", app_wr_next); end
    n_cmp++; if (app_rd_valid !== 2'b00) begin n_err++; $display("[TB] FAIL rst_rd_valid: got %b want 00", app_rd_valid); end
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b want 0", arb_busy); end
    n_cmp++; if (arb_grant !== 1'b0) begin n_err++; $display("[TB] FAIL rst_grant: got %b want 0", arb_grant); end
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_write_port0();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    d = $urandom;
    clear_inputs();
    app_req = 2'b01; app_req_addr[AW-1:0] = a; app_req_len[RW-1:0] = 9'd4;
    app_wr_data[DW-1:0] = d; app_wr_en_n[BW-1:0] = 4'h5;
    settle();
    n_cmp++; if (mc_req !== 1'b0) begin n_err++; $display("[TB] FAIL wr_latency: mc_req got %b want 0", mc_req); end
    cyc();
    settle();
    n_cmp++; if (mc_req !== 1'b1) begin n_err++; $display("[TB] FAIL wr_mc_req: got %b want 1", mc_req); end
    n_cmp++; if ({mc_req_addr, mc_req_len, mc_req_wr_n, mc_wr_data, mc_wr_en_n} !== {a, 9'd4, 1'b0, d, 4'h5}) begin
      n_err++; $display("[TB] FAIL wr_mux: got %h/%0d/%b/%h/%h want %h/4/0/%h/5",
                        mc_req_addr, mc_req_len, mc_req_wr_n, mc_wr_data, mc_wr_en_n, a, d);
    end
    mc_req_ack = 1'b1;
    settle();
    n_cmp++; if (app_req_ack !== 2'b01) begin n_err++; $display("[TB] FAIL wr_ack: got %b want 01", app_req_ack); end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mc_wr_next = 1'b1;
      settle();
      n_cmp++; if (app_wr_next !== 2'b01) begin n_err++; $display("[TB] FAIL wr_beat%0d: got %b want 01", i, app_wr_next); end
      cyc();
    end
    mc_wr_next = 1'b0;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL wr_done_busy: got %b want 0", arb_busy); end
  endtask

  task automatic test_two_ports();
    logic [DW-1:0] r;
    do_reset();
    app_req = 2'b11; app_req_len = {9'd2, 9'd1}; app_req_wr_n = 2'b10;
    cyc();
    settle();
    n_cmp++; if (arb_grant !== 1'b0) begin n_err++; $display("[TB] FAIL two_first_grant: got %b want 0", arb_grant); end
    mc_req_ack = 1'b1;
    settle();
    n_cmp++; if (app_req_ack !== 2'b01) begin n_err++; $display("[TB] FAIL two_ack0: got %b want 01", app_req_ack); end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b10; mc_wr_next = 1'b1;
    settle();
    n_cmp++; if ({app_wr_next, app_req_ack} !== 4'b0100) begin
      n_err++; $display("[TB] FAIL two_beat0: wr_next/ack got %b/%b want 01/00", app_wr_next, app_req_ack);
    end
    cyc();
    mc_wr_next = 1'b0;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL two_gap: busy got %b want 0", arb_busy); end
    cyc();
    settle();
    n_cmp++; if ({arb_grant, mc_req_wr_n, mc_req_len} !== {1'b1, 1'b1, 9'd2}) begin
      n_err++; $display("[TB] FAIL two_second: grant/wr_n/len got %b/%b/%0d want 1/1/2", arb_grant, mc_req_wr_n, mc_req_len);
    end
    mc_req_ack = 1'b1;
    settle();
    n_cmp++; if (app_req_ack !== 2'b10) begin n_err++; $display("[TB] FAIL two_ack1: got %b want 10", app_req_ack); end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      mc_rd_valid = 1'b1; mc_rd_data = r;
      settle();
      n_cmp++; if (app_rd_valid !== 2'b10) begin n_err++; $display("[TB] FAIL two_rd_valid%0d: got %b want 10", i, app_rd_valid); end
      n_cmp++; if (app_rd_data !== r) begin n_err++; $display("[TB] FAIL two_rd_data%0d: got %h want %h", i, app_rd_data, r); end
      cyc();
    end
    mc_rd_valid = 1'b0;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL two_done_busy: got %b want 0", arb_busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] oh;
    do_reset();
    app_req = 2'b11; app_req_len = {9'd1, 9'd1}; app_req_wr_n = 2'b00;
    mc_req_ack = 1'b1; mc_wr_next = 1'b1;
    for (int k = 0; k < 6; k++) begin
      oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      settle();
      n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL fair_idle%0d: busy got %b want 0", k, arb_busy); end
      cyc();
      settle();
      n_cmp++; if ({arb_grant, app_req_ack} !== {oh[1], oh}) begin
        n_err++; $display("[TB] FAIL fair_grant%0d: grant/ack got %b/%b want %b/%b", k, arb_grant, app_req_ack, oh[1], oh);
      end
      cyc();
      settle();
      n_cmp++; if ({app_wr_next, app_req_ack} !== {oh, 2'b00}) begin
        n_err++; $display("[TB] FAIL fair_beat%0d: wr_next/ack got %b/%b want %b/00", k, app_wr_next, app_req_ack, oh);
      end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_spurious_strobes();
    logic [5:0] pat;
    pat = 6'b110010;
    clear_inputs();
    app_req = 2'b01; app_req_len[RW-1:0] = 9'd3; app_req_wr_n = 2'b01;
    cyc();
    mc_req_ack = 1'b1;
    settle();
    n_cmp++; if (app_req_ack !== 2'b01) begin n_err++; $display("[TB] FAIL spur_ack: got %b want 01", app_req_ack); end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      mc_rd_valid = pat[i]; mc_wr_next = ~pat[i];
      settle();
      n_cmp++; if ({arb_busy, app_rd_valid, app_wr_next} !== {1'b1, 1'b0, pat[i], 2'b00}) begin
        n_err++; $display("[TB] FAIL spur_step%0d: busy/rd/wr got %b/%b/%b want 1/0%b/00", i, arb_busy, app_rd_valid, app_wr_next, pat[i]);
      end
      cyc();
    end
    mc_rd_valid = 1'b0; mc_wr_next = 1'b0;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL spur_done_busy: got %b want 0", arb_busy); end
  endtask

  task automatic test_len_zero();
    clear_inputs();
    app_req = 2'b10;
    cyc();
    settle();
    n_cmp++; if ({arb_grant, mc_req} !== 2'b11) begin n_err++; $display("[TB] FAIL len0_req: grant/mc_req got %b/%b want 1/1", arb_grant, mc_req); end
    mc_req_ack = 1'b1;
    settle();
    n_cmp++; if (app_req_ack !== 2'b10) begin n_err++; $display("[TB] FAIL len0_ack: got %b want 10", app_req_ack); end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL len0_no_xfer: busy got %b want 0", arb_busy); end
    app_req = 2'b11;
    cyc();
    settle();
    n_cmp++; if (arb_grant !== 1'b0) begin n_err++; $display("[TB] FAIL len0_last_served: grant got %b want 0", arb_grant); end
    app_req = 2'b10; mc_req_ack = 1'b1;
    settle();
    n_cmp++; if ({mc_req, app_req_ack} !== 3'b000) begin
      n_err++; $display("[TB] FAIL drop_no_ack: mc_req/ack got %b/%b want 0/00", mc_req, app_req_ack);
    end
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    settle();
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("[TB] FAIL drop_idle: busy got %b want 0", arb_busy); end
    app_req = 2'b11;
    cyc();
    settle();
    n_cmp++; if (arb_grant !== 1'b0) begin n_err++; $display("[TB] FAIL drop_last_kept: grant got %b want 0", arb_grant); end
    app_req = 2'b00;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    app_req = 2'b10; app_req_len[2*RW-1:RW] = 9'd8;
    cyc();
    mc_req_ack = 1'b1;
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mc_wr_next = 1'b1;
      settle();
      n_cmp++; if (app_wr_next !== 2'b10) begin n_err++; $display("[TB] FAIL mid_beat%0d: got %b want 10", i, app_wr_next); end
      cyc();
    end
    mc_wr_next = 1'b0; reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    settle();
    n_cmp++; if ({arb_busy, arb_grant, mc_req, app_req_ack, app_wr_next, app_rd_valid} !== 9'b0) begin
      n_err++; $display("[TB] FAIL mid_reset_outs: busy/grant/req/ack/wr/rd got %b/%b/%b/%b/%b/%b want all 0",
                        arb_busy, arb_grant, mc_req, app_req_ack, app_wr_next, app_rd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      mc_wr_next = 1'b1; mc_rd_valid = 1'b1;
      settle();
      n_cmp++; if ({app_wr_next, app_rd_valid} !== 4'b0) begin
        n_err++; $display("[TB] FAIL mid_stale%0d: wr/rd got %b/%b want 00/00", i, app_wr_next, app_rd_valid);
      end
      cyc();
    end
    mc_wr_next = 1'b0; mc_rd_valid = 1'b0; app_req = 2'b11;
    cyc();
    settle();
    n_cmp++; if (arb_grant !== 1'b0) begin n_err++; $display("[TB] FAIL mid_regrant: got %b want 0", arb_grant); end
    app_req = 2'b00;
    cyc();
  endtask

  task automatic test_max_len();
    int cnt;
    logic busy_last;
    cnt = 0;
    busy_last = 1'b0;
    clear_inputs();
    app_req = 2'b01; app_req_len[RW-1:0] = 9'd511;
    cyc();
    mc_req_ack = 1'b1;
    cyc();
    mc_req_ack = 1'b0; app_req = 2'b00; mc_wr_next = 1'b1;
    for (int i = 0; i < 511; i++) begin
      settle();
      if (app_wr_next == 2'b01) cnt++;
      if (i == 510) busy_last = arb_busy;
      cyc();
    end
    mc_wr_next = 1'b0;
    settle();
    n_cmp++; if (cnt !== 511) begin n_err++; $display("[TB] FAIL max_beats: got %0d want 511", cnt); end
    n_cmp++; if ({busy_last, arb_busy} !== 2'b10) begin
      n_err++; $display("[TB] FAIL max_busy: before/after last beat got %b/%b want 1/0", busy_last, arb_busy);
    end
  endtask

  task automatic test_random();
    int m_owner, m_last, m_beats;
    logic m_acked, m_read, m_grant;
    logic [1:0] e_ack, e_wn, e_rv;
    logic e_req;
    logic [AW-1:0] a0, a1;
    logic [RW-1:0] l0, l1, lo;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] b0, b1;
    do_reset();
    m_owner = -1; m_last = 1; m_beats = 0; m_acked = 1'b0; m_read = 1'b0; m_grant = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      a0 = AW'($urandom); a1 = AW'($urandom);
      l0 = RW'($urandom_range(0, 5)); l1 = RW'($urandom_range(0, 5));
      d0 = $urandom; d1 = $urandom; b0 = BW'($urandom); b1 = BW'($urandom);
      app_req = {($urandom % 10) < 6, ($urandom % 10) < 6};
      app_req_addr = {a1, a0}; app_req_len = {l1, l0}; app_wr_data = {d1, d0}; app_wr_en_n = {b1, b0};
      app_req_wr_n = 2'($urandom); app_req_dma_last = 2'($urandom);
      mc_req_ack = ($urandom % 3) == 0; mc_wr_next = 1'($urandom); mc_rd_valid = 1'($urandom);
      mc_rd_data = $urandom;
      settle();
      e_req = 1'b0; e_ack = 2'b00; e_wn = 2'b00; e_rv = 2'b00;
      if (m_owner >= 0 && !m_acked) begin
        e_req = app_req[m_owner];
        if (app_req[m_owner] && mc_req_ack) e_ack[m_owner] = 1'b1;
      end
      if (m_owner >= 0 && m_acked) begin
        if (m_read) e_rv[m_owner] = mc_rd_valid;
        else        e_wn[m_owner] = mc_wr_next;
      end
      n_cmp++; if ({mc_req, app_req_ack, app_wr_next, app_rd_valid, arb_busy, arb_grant} !==
                   {e_req, e_ack, e_wn, e_rv, (m_owner >= 0), m_grant}) begin
        n_err++; $display("[TB] FAIL rnd_ctrl c=%0d: req/ack/wr/rd/busy/grant got %b/%b/%b/%b/%b/%b want %b/%b/%b/%b/%b/%b",
                          c, mc_req, app_req_ack, app_wr_next, app_rd_valid, arb_busy, arb_grant,
                          e_req, e_ack, e_wn, e_rv, (m_owner >= 0), m_grant);
      end
      n_cmp++; if ({mc_req_addr, mc_req_len, mc_req_wr_n, mc_req_dma_last, mc_wr_data, mc_wr_en_n, app_rd_data} !==
                   {(m_grant ? a1 : a0), (m_grant ? l1 : l0), app_req_wr_n[m_grant], app_req_dma_last[m_grant],
                    (m_grant ? d1 : d0), (m_grant ? b1 : b0), mc_rd_data}) begin
        n_err++; $display("[TB] FAIL rnd_data c=%0d: addr/len/data got %h/%0d/%h for grant %b", c, mc_req_addr, mc_req_len, mc_wr_data, m_grant);
      end
      if (m_owner < 0) begin
        if (|app_req) begin
          m_owner = (&app_req) ? 1 - m_last : (app_req[1] ? 1 : 0);
          m_grant = m_owner[0];
          m_acked = 1'b0;
        end
      end else if (!m_acked) begin
        lo = m_owner[0] ? l1 : l0;
        if (!app_req[m_owner]) m_owner = -1;
        else if (mc_req_ack) begin
          if (lo == 0) begin m_last = m_owner; m_owner = -1; end
          else begin m_acked = 1'b1; m_beats = int'(lo); m_read = app_req_wr_n[m_owner]; end
        end
      end else if (m_read ? mc_rd_valid : mc_wr_next) begin
        m_beats--;
        if (m_beats == 0) begin m_last = m_owner; m_owner = -1; m_acked = 1'b0; end
      end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_write_port0();
    test_two_ports();
    test_fairness();
    test_spurious_strobes();
    test_len_zero();
    test_reset_mid_burst();
    test_max_len();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
